// File: rtl/clk_div_pair.sv
// Two-channel programmable integer clock divider with boundary-safe ratio updates.
// Define CLK_DIV_PHASE_ALIGN_EN to apply both ratios together at channel 1's boundary.
module clk_div_pair #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_ratio1,
   input  logic [CNT_W-1:0] cfg_ratio2,
   output logic             div1_out,
   output logic             div2_out,
   output logic             div1_tick,
   output logic             div2_tick
);

   typedef enum logic [1:0] {StStop, StRun, StPend} ch_state_e;

   ch_state_e        r_state [2];
   logic [CNT_W-1:0] r_n     [2];
   logic [CNT_W-1:0] r_pnd   [2];
   logic [CNT_W-1:0] r_cnt   [2];
   logic             r_out   [2];

   logic [CNT_W-1:0] w_new    [2];
   logic [CNT_W-1:0] w_cnt_nx [2];
   logic             w_run    [2];
   logic             w_bnd    [2];
   logic             w_apply  [2];
   logic             w_load   [2];
   logic             w_topend [2];
   logic             w_acc;

   function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] r);
      return (r == CNT_W'(1)) ? CNT_W'(2) : r;
   endfunction

   // High for the first ceil(n/2) counts of a period.
   function automatic logic f_high(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] n);
      logic [CNT_W:0] w_half;
      w_half = ({1'b0, n} + (CNT_W+1)'(1)) >> 1;
      return {1'b0, c} < w_half;
   endfunction

   assign cfg_ready = (r_state[0] != StPend) && (r_state[1] != StPend);

   always_comb begin
      w_new[0] = f_clamp(cfg_ratio1);
      w_new[1] = f_clamp(cfg_ratio2);
      w_acc    = cfg_valid && cfg_ready;
      for (int i = 0; i < 2; i++) begin
         w_run[i]    = (r_n[i] != '0);
         w_bnd[i]    = w_run[i] && en && (r_cnt[i] == r_n[i] - CNT_W'(1));
         w_cnt_nx[i] = w_bnd[i] ? '0 : r_cnt[i] + CNT_W'(1);
`ifdef CLK_DIV_PHASE_ALIGN_EN
         // Channel 1 alone decides when the shared ratio pair lands.
         w_apply[i]  = (r_state[0] == StPend) && w_bnd[0];
         w_load[i]   = w_acc && (r_state[0] == StStop);
         w_topend[i] = w_acc && (r_state[0] != StStop);
`else
         w_apply[i]  = (r_state[i] == StPend) && w_bnd[i];
         w_load[i]   = w_acc && (r_state[i] == StStop);
         w_topend[i] = w_acc && (r_state[i] != StStop);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= StStop;
            r_n[i]     <= '0;
            r_pnd[i]   <= '0;
            r_cnt[i]   <= '0;
            r_out[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_load[i]) begin
               r_n[i]     <= w_new[i];
               r_cnt[i]   <= '0;
               r_out[i]   <= (w_new[i] != '0);
               r_state[i] <= (w_new[i] != '0) ? StRun : StStop;
            end else if (w_apply[i]) begin
               r_n[i]     <= r_pnd[i];
               r_cnt[i]   <= '0;
               r_out[i]   <= (r_pnd[i] != '0);
               r_state[i] <= (r_pnd[i] != '0) ? StRun : StStop;
            end else begin
               // An accept on a boundary edge only captures; the wrap keeps the old ratio.
               if (w_topend[i]) begin
                  r_pnd[i]   <= w_new[i];
                  r_state[i] <= StPend;
               end
               if (w_run[i] && en) begin
                  r_cnt[i] <= w_cnt_nx[i];
                  r_out[i] <= f_high(w_cnt_nx[i], r_n[i]);
               end
            end
         end
      end
   end

   assign div1_out  = r_out[0];
   assign div2_out  = r_out[1];
   assign div1_tick = w_bnd[0];
   assign div2_tick = w_bnd[1];

endmodule

// File: tb/tb_clk_div_pair.sv
// Directed self-checking bench for clk_div_pair; the alignment section runs only
// when CLK_DIV_PHASE_ALIGN_EN is defined.
module tb_clk_div_pair;

   logic       clk = 1'b0;
   logic       rst_n, en, cfg_valid, cfg_ready;
   logic [7:0] cfg_ratio1, cfg_ratio2;
   logic       div1_out, div2_out, div1_tick, div2_tick;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   clk_div_pair #(.CNT_W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ratio1 (cfg_ratio1),
      .cfg_ratio2 (cfg_ratio2),
      .div1_out   (div1_out),
      .div2_out   (div2_out),
      .div1_tick  (div1_tick),
      .div2_tick  (div2_tick)
   );

   always #5 clk = ~clk;

   task automatic tk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic acc(input logic [7:0] r1, input logic [7:0] r2);
      cfg_ratio1 = r1;
      cfg_ratio2 = r2;
      cfg_valid  = 1'b1;
      tk();
      cfg_valid  = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      tk();
      chk({tag, "_out1"}, div1_out, 0);
      chk({tag, "_out2"}, div2_out, 0);
      chk({tag, "_rdy"}, cfg_ready, 1);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [11:0] chg_out, chg_rdy, chg_tick;
      logic [16:0] frz_out, frz_tick;
      logic [3:0]  p1;
      logic [4:0]  p2;

      // Reset held with a configuration request pending
      rst_n = 1'b0; en = 1'b1; cfg_valid = 1'b1; cfg_ratio1 = 8'd4; cfg_ratio2 = 8'd5;
      for (int i = 0; i < 3; i++) begin
         tk();
         chk($sformatf("rst%0d_out1", i), div1_out, 0);
         chk($sformatf("rst%0d_out2", i), div2_out, 0);
         chk($sformatf("rst%0d_tick1", i), div1_tick, 0);
         chk($sformatf("rst%0d_tick2", i), div2_tick, 0);
         chk($sformatf("rst%0d_rdy", i), cfg_ready, 1);
      end
      rst_n = 1'b1; cfg_valid = 1'b0;
      tk();
      chk("post_rst_out1", div1_out, 0);
      chk("post_rst_out2", div2_out, 0);
      chk("post_rst_rdy", cfg_ready, 1);

      // Basic divide: 4 -> 1100, 5 -> 11100
      p1 = 4'b1100;
      p2 = 5'b11100;
      acc(8'd4, 8'd5);
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("basic%0d_out1", k), div1_out, p1[3 - (k % 4)]);
         chk($sformatf("basic%0d_out2", k), div2_out, p2[4 - (k % 5)]);
         chk($sformatf("basic%0d_tick1", k), div1_tick, (k % 4) == 3);
         chk($sformatf("basic%0d_tick2", k), div2_tick, (k % 5) == 4);
         chk($sformatf("basic%0d_rdy", k), cfg_ready, 1);
         tk();
      end

      // Ratio change 6 -> 2 accepted with cnt landing on 1
      do_reset("rst_mid");
      acc(8'd6, 8'd0);
      acc(8'd2, 8'd0);
      chg_out  = 12'b110001010101;
      chg_rdy  = 12'b000001111111;
      chg_tick = 12'b000010101010;
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("chg%0d_out1", j), div1_out, chg_out[11 - j]);
         chk($sformatf("chg%0d_rdy", j), cfg_ready, chg_rdy[11 - j]);
         chk($sformatf("chg%0d_tick1", j), div1_tick, chg_tick[11 - j]);
         chk($sformatf("chg%0d_out2", j), div2_out, 0);
         if (j < 11) tk();
      end

      // Ratio 1 clamps to 2, then ratio 0 stops at the boundary
      do_reset("rst_clamp");
      acc(8'd1, 8'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("clamp%0d_out1", k), div1_out, (k % 2) == 0);
         chk($sformatf("clamp%0d_tick1", k), div1_tick, (k % 2) == 1);
         tk();
      end
      acc(8'd0, 8'd0);
      chk("stop0_out1", div1_out, 0);
      chk("stop0_tick1", div1_tick, 1);
      chk("stop0_rdy", cfg_ready, 0);
      for (int m = 1; m < 6; m++) begin
         tk();
         chk($sformatf("stop%0d_out1", m), div1_out, 0);
         chk($sformatf("stop%0d_tick1", m), div1_tick, 0);
         chk($sformatf("stop%0d_rdy", m), cfg_ready, 1);
      end

      // Freeze: ratio 8, en low for 7 cycles at cnt 3 -> 15-cycle period
      do_reset("rst_frz");
      acc(8'd8, 8'd0);
      frz_out  = 17'b11111111111000011;
      frz_tick = 17'b00000000000000100;
      for (int t = 0; t < 17; t++) begin
         en = (t >= 3 && t <= 9) ? 1'b0 : 1'b1;
         chk($sformatf("frz%0d_out1", t), div1_out, frz_out[16 - t]);
         chk($sformatf("frz%0d_tick1", t), div1_tick, frz_tick[16 - t]);
         tk();
      end
      en = 1'b1;

`ifdef CLK_DIV_PHASE_ALIGN_EN
      // Phase alignment: 3/7 pair applied together at channel 1's boundary
      do_reset("rst_aln");
      acc(8'd4, 8'd5);
      repeat (6) tk();
      acc(8'd3, 8'd7);
      chk("aln_pend_rdy", cfg_ready, 0);
      chk("aln_pend_out1", div1_out, 0);
      chk("aln_pend_out2", div2_out, 1);
      tk();
      for (int b = 0; b < 22; b++) begin
         chk($sformatf("aln%0d_out1", b), div1_out, (b % 3) < 2);
         chk($sformatf("aln%0d_out2", b), div2_out, (b % 7) < 4);
         chk($sformatf("aln%0d_rdy", b), cfg_ready, 1);
         tk();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
